// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Brief    : Runner-game frame controller. Tracks IDLE / PLAYING / CRASHED,
//             turns the jump button into one-shot jump or restart pulses,
//             accumulates distance into a five-digit BCD score, ramps scroll
//             speed and keeps the best score.
//  Ports    : clk       - frame clock, one rising edge per displayed frame
//             rst       - asynchronous active-low reset
//             jump_btn  - player button level
//             collision - 1 while the character overlaps an obstacle
//             timer     - free-running animation counter 0..59
//             speed     - current scroll speed
//             jump      - one-cycle jump request
//             crash     - 1 while in CRASHED
//             restart   - one-cycle pulse resetting character/obstacles
//             state     - IDLE=0, PLAYING=1, CRASHED=2
//             score     - BCD score, digit 0 in [3:0]
//             hi_score  - BCD best score
//  Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int SPEED_INIT     = 6,
    parameter int SPEED_MAX      = 13,
    parameter int SPEED_STEP     = 300,
    parameter int DIST_PER_POINT = 40,
    parameter int RESTART_DELAY  = 45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_btn,
    input  logic        collision,
    output logic [5:0]  timer,
    output logic [4:0]  speed,
    output logic        jump,
    output logic        crash,
    output logic        restart,
    output logic [1:0]  state,
    output logic [19:0] score,
    output logic [19:0] hi_score
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PLAYING = 2'd1;
    localparam logic [1:0] c_CRASHED = 2'd2;

    localparam int c_SCW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam int c_CCW = $clog2(RESTART_DELAY + 1);

    localparam logic [4:0]       c_SPEED_INIT = 5'(SPEED_INIT);
    localparam logic [4:0]       c_SPEED_MAX  = 5'(SPEED_MAX);
    localparam logic [6:0]       c_DIST       = 7'(DIST_PER_POINT);
    localparam logic [c_SCW-1:0] c_STEP_LAST  = c_SCW'(SPEED_STEP - 1);
    localparam logic [c_CCW-1:0] c_DELAY      = c_CCW'(RESTART_DELAY);
    localparam logic [19:0]      c_SCORE_SAT  = 20'h99999;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_btn_q;
    logic [5:0]       r_timer;
    logic [4:0]       r_speed;
    logic             r_jump;
    logic             r_crash;
    logic             r_restart;
    logic [19:0]      r_score;
    logic [19:0]      r_hi_score;
    logic [5:0]       r_acc;
    logic [c_SCW-1:0] r_speed_cnt;
    logic [c_CCW-1:0] r_crash_cnt;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic             w_press;
    logic [1:0]       w_state_next;
    logic             w_jump_next;
    logic             w_restart_next;
    logic             w_tick;
    logic             w_crash_evt;
    logic [6:0]       w_sum;
    logic [5:0]       w_timer_next;
    logic [4:0]       w_speed_next;
    logic [19:0]      w_score_next;
    logic [19:0]      w_hi_next;
    logic [5:0]       w_acc_next;
    logic [c_SCW-1:0] w_speed_cnt_next;
    logic [c_CCW-1:0] w_crash_cnt_next;

    // Rising edge of the button: a held button produces a single press.
    assign w_press = jump_btn & ~r_btn_q;

    // BCD +1 with per-digit carry; holds at 99999 instead of wrapping.
    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != c_SCORE_SAT) begin
            for (int i = 0; i < 5; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        res[i*4 +: 4] = 4'd0;
                    end else begin
                        res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_jump    <= 1'b0;
            r_restart <= 1'b0;
            r_crash   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_jump    <= w_jump_next;
            r_restart <= w_restart_next;
            r_crash   <= (w_state_next == c_CRASHED);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and pulse outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_jump_next    = 1'b0;
        w_restart_next = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_press) begin
                    w_state_next = c_PLAYING;
                    w_jump_next  = 1'b1;
                end
            end
            c_PLAYING: begin
                // A collision wins over a press in the same frame.
                if (collision) begin
                    w_state_next = c_CRASHED;
                end else if (w_press) begin
                    w_jump_next = 1'b1;
                end
            end
            c_CRASHED: begin
                // Early presses are simply dropped, never remembered.
                if (w_press && (r_crash_cnt == c_DELAY)) begin
                    w_state_next   = c_PLAYING;
                    w_restart_next = 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    assign w_tick      = (r_state == c_PLAYING) && !collision;
    assign w_crash_evt = (r_state == c_PLAYING) && collision;
    assign w_sum       = {1'b0, r_acc} + {2'b00, r_speed};

    always_comb begin
        w_timer_next     = (r_timer == 6'd59) ? 6'd0 : r_timer + 6'd1;
        w_speed_next     = r_speed;
        w_score_next     = r_score;
        w_hi_next        = r_hi_score;
        w_acc_next       = r_acc;
        w_speed_cnt_next = r_speed_cnt;
        w_crash_cnt_next = r_crash_cnt;

        if (w_restart_next) begin
            w_speed_next     = c_SPEED_INIT;
            w_score_next     = 20'h00000;
            w_acc_next       = 6'd0;
            w_speed_cnt_next = '0;
        end else if (w_tick) begin
            // Distance uses the speed in effect during this frame.
            if (w_sum >= c_DIST) begin
                w_acc_next   = 6'(w_sum - c_DIST);
                w_score_next = bcd_inc(r_score);
            end else begin
                w_acc_next = w_sum[5:0];
            end
            if (r_speed_cnt == c_STEP_LAST) begin
                w_speed_cnt_next = '0;
                if (r_speed < c_SPEED_MAX) begin
                    w_speed_next = r_speed + 5'd1;
                end
            end else begin
                w_speed_cnt_next = r_speed_cnt + 1'b1;
            end
        end

        // Valid BCD orders the same as binary, so a plain compare suffices.
        if (w_crash_evt && (r_score > r_hi_score)) begin
            w_hi_next = r_score;
        end

        if (w_crash_evt) begin
            w_crash_cnt_next = '0;
        end else if ((r_state == c_CRASHED) && (r_crash_cnt != c_DELAY)) begin
            w_crash_cnt_next = r_crash_cnt + 1'b1;
        end
    end

    // Datapath registers take their next value every frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_q     <= 1'b0;
            r_timer     <= 6'd0;
            r_speed     <= c_SPEED_INIT;
            r_score     <= 20'h00000;
            r_hi_score  <= 20'h00000;
            r_acc       <= 6'd0;
            r_speed_cnt <= '0;
            r_crash_cnt <= '0;
        end else begin
            r_btn_q     <= jump_btn;
            r_timer     <= w_timer_next;
            r_speed     <= w_speed_next;
            r_score     <= w_score_next;
            r_hi_score  <= w_hi_next;
            r_acc       <= w_acc_next;
            r_speed_cnt <= w_speed_cnt_next;
            r_crash_cnt <= w_crash_cnt_next;
        end
    end

    assign timer    = r_timer;
    assign speed    = r_speed;
    assign jump     = r_jump;
    assign crash    = r_crash;
    assign restart  = r_restart;
    assign state    = r_state;
    assign score    = r_score;
    assign hi_score = r_hi_score;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_ctrl
//  Brief    : Directed self-checking bench for game_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_btn;
    logic        collision;
    logic [5:0]  timer;
    logic [4:0]  speed;
    logic        jump;
    logic        crash;
    logic        restart;
    logic [1:0]  state;
    logic [19:0] score;
    logic [19:0] hi_score;

    int checks;
    int errors;

    game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .jump_btn  (jump_btn),
        .collision (collision),
        .timer     (timer),
        .speed     (speed),
        .jump      (jump),
        .crash     (crash),
        .restart   (restart),
        .state     (state),
        .score     (score),
        .hi_score  (hi_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse reset low and release it at a falling clock edge.
    task automatic reset_dut();
        @(negedge clk);
        jump_btn  = 1'b0;
        collision = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // From IDLE, press once and release: leaves the game in PLAYING.
    task automatic start_game();
        jump_btn = 1'b1;
        tick(1);
        jump_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_btn = 1'b0; collision = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (timer !== 6'd0) begin errors++; $display("FAIL reset_timer got %0d exp 0", timer); end
        checks++; if (speed !== 5'd6) begin errors++; $display("FAIL reset_speed got %0d exp 6", speed); end
        checks++; if (score !== 20'h0) begin errors++; $display("FAIL reset_score got %h exp 00000", score); end
        checks++; if (hi_score !== 20'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000", hi_score); end
        checks++; if ({jump, crash, restart} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {jump, crash, restart}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_start();
        reset_dut();
        jump_btn = 1'b1;
        tick(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", state); end
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL start_jump got %b exp 1", jump); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (jump !== 1'b0) begin errors++; $display("FAIL held_btn_jump cycle %0d got %b exp 0", i, jump); end
        end
        jump_btn = 1'b0;
        tick(1);
        jump_btn = 1'b1;
        tick(1);
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL play_jump got %b exp 1", jump); end
        jump_btn = 1'b0;
        tick(1);
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL play_jump_end got %b exp 0", jump); end
    endtask

    task automatic test_scoring();
        reset_dut();
        start_game();
        tick(6);
        checks++; if (score !== 20'h00000) begin errors++; $display("FAIL score_6cyc got %h exp 00000", score); end
        checks++; if (dut.r_acc !== 6'd36) begin errors++; $display("FAIL acc_6cyc got %0d exp 36", dut.r_acc); end
        tick(1);
        checks++; if (score !== 20'h00001) begin errors++; $display("FAIL score_7cyc got %h exp 00001", score); end
        checks++; if (dut.r_acc !== 6'd2) begin errors++; $display("FAIL acc_7cyc got %0d exp 2", dut.r_acc); end

        // BCD carry from digit 0 into digit 1.
        reset_dut();
        force dut.r_score = 20'h00009;
        tick(1);
        release dut.r_score;
        start_game();
        tick(6);
        checks++; if (score !== 20'h00009) begin errors++; $display("FAIL score_pre_carry got %h exp 00009", score); end
        tick(1);
        checks++; if (score !== 20'h00010) begin errors++; $display("FAIL score_carry got %h exp 00010", score); end

        // Saturation.
        reset_dut();
        force dut.r_score = 20'h99999;
        tick(1);
        release dut.r_score;
        start_game();
        tick(7);
        checks++; if (score !== 20'h99999) begin errors++; $display("FAIL score_sat got %h exp 99999", score); end
    endtask

    task automatic test_speed();
        reset_dut();
        start_game();
        tick(299);
        checks++; if (speed !== 5'd6) begin errors++; $display("FAIL speed_299 got %0d exp 6", speed); end
        tick(1);
        checks++; if (speed !== 5'd7) begin errors++; $display("FAIL speed_300 got %0d exp 7", speed); end
        // 300 frames at speed 6 = 1800 distance = exactly 45 points.
        checks++; if (score !== 20'h00045) begin errors++; $display("FAIL score_300 got %h exp 00045", score); end
        checks++; if (dut.r_acc !== 6'd0) begin errors++; $display("FAIL acc_300 got %0d exp 0", dut.r_acc); end
        tick(1799);
        checks++; if (speed !== 5'd12) begin errors++; $display("FAIL speed_2099 got %0d exp 12", speed); end
        tick(1);
        checks++; if (speed !== 5'd13) begin errors++; $display("FAIL speed_2100 got %0d exp 13", speed); end
        tick(400);
        checks++; if (speed !== 5'd13) begin errors++; $display("FAIL speed_sat got %0d exp 13", speed); end
    endtask

    task automatic test_crash_restart();
        reset_dut();
        force dut.r_score    = 20'h00123;
        force dut.r_hi_score = 20'h00050;
        tick(1);
        release dut.r_score;
        release dut.r_hi_score;
        checks++; if (hi_score !== 20'h00050) begin errors++; $display("FAIL hi_preload got %h exp 00050", hi_score); end
        start_game();
        tick(1);
        jump_btn  = 1'b1;
        collision = 1'b1;
        tick(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_state got %0d exp 2", state); end
        checks++; if (crash !== 1'b1) begin errors++; $display("FAIL crash_level got %b exp 1", crash); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL crash_jump got %b exp 0", jump); end
        checks++; if (hi_score !== 20'h00123) begin errors++; $display("FAIL crash_hi got %h exp 00123", hi_score); end
        checks++; if (score !== 20'h00123) begin errors++; $display("FAIL crash_score got %h exp 00123", score); end
        jump_btn  = 1'b0;
        collision = 1'b0;

        // Press 10 frames into CRASHED: dropped.
        tick(9);
        jump_btn = 1'b1;
        tick(1);
        checks++; if ({state, restart} !== 3'b100) begin errors++; $display("FAIL early_press got %b exp 100", {state, restart}); end
        jump_btn = 1'b0;
        // Press one frame before the delay expires: still dropped.
        tick(34);
        jump_btn = 1'b1;
        tick(1);
        checks++; if ({state, restart} !== 3'b100) begin errors++; $display("FAIL press_at_44 got %b exp 100", {state, restart}); end
        jump_btn = 1'b0;
        tick(1);
        checks++; if (dut.r_crash_cnt !== 6'd45) begin errors++; $display("FAIL crash_cnt_sat got %0d exp 45", dut.r_crash_cnt); end
        jump_btn = 1'b1;
        tick(1);
        checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b exp 1", restart); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state got %0d exp 1", state); end
        checks++; if ({jump, crash} !== 2'b00) begin errors++; $display("FAIL restart_jc got %b exp 00", {jump, crash}); end
        checks++; if (score !== 20'h0) begin errors++; $display("FAIL restart_score got %h exp 00000", score); end
        checks++; if (speed !== 5'd6) begin errors++; $display("FAIL restart_speed got %0d exp 6", speed); end
        checks++; if (hi_score !== 20'h00123) begin errors++; $display("FAIL restart_hi got %h exp 00123", hi_score); end
        jump_btn = 1'b0;
        tick(1);
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_end got %b exp 0", restart); end

        // Lower score crash leaves the best score alone.
        force dut.r_score = 20'h00010;
        collision = 1'b1;
        tick(1);
        release dut.r_score;
        collision = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash2_state got %0d exp 2", state); end
        checks++; if (hi_score !== 20'h00123) begin errors++; $display("FAIL crash2_hi got %h exp 00123", hi_score); end
        checks++; if (score !== 20'h00010) begin errors++; $display("FAIL crash2_score got %h exp 00010", score); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        start_game();
        tick(20);
        checks++; if (score !== 20'h00003) begin errors++; $display("FAIL pre_reset_score got %h exp 00003", score); end
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
        checks++; if (score !== 20'h0) begin errors++; $display("FAIL async_score got %h exp 00000", score); end
        checks++; if (timer !== 6'd0) begin errors++; $display("FAIL async_timer got %0d exp 0", timer); end
        checks++; if (speed !== 5'd6) begin errors++; $display("FAIL async_speed got %0d exp 6", speed); end
        checks++; if (hi_score !== 20'h0) begin errors++; $display("FAIL async_hi got %h exp 00000", hi_score); end
        checks++; if ({jump, crash, restart} !== 3'b000) begin errors++; $display("FAIL async_pulses got %b exp 000", {jump, crash, restart}); end
        @(negedge clk);
        rst = 1'b1;
        tick(59);
        checks++; if (timer !== 6'd59) begin errors++; $display("FAIL timer_59 got %0d exp 59", timer); end
        tick(1);
        checks++; if (timer !== 6'd0) begin errors++; $display("FAIL timer_wrap got %0d exp 0", timer); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        jump_btn  = 1'b0;
        collision = 1'b0;
        test_reset();
        test_start();
        test_scoring();
        test_speed();
        test_crash_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SPEED_INIT, default 6, speed value after reset and after restart.
REQ-002 Parameter SPEED_MAX, default 13, speed saturation value.
REQ-003 Parameter SPEED_STEP, default 300, PLAYING cycles per speed increment.
REQ-004 Parameter DIST_PER_POINT, default 40, accumulated distance per score point.
REQ-005 Parameter RESTART_DELAY, default 45, CRASHED cycles before a restart press is accepted.
REQ-006 clk  in  1  game frame clock, one rising edge per displayed frame; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-008 jump_btn  in  1  player button level, synchronous to clk.
REQ-009 collision  in  1  level from the collision checker, 1 = character overlaps an obstacle.
REQ-010 timer  out  6  free-running animation counter, 0..59.
REQ-011 speed  out  5  current scroll speed.
REQ-012 jump  out  1  one-cycle jump request to the character.
REQ-013 crash  out  1  level, 1 while in CRASHED.
REQ-014 restart  out  1  one-cycle pulse that resets the character and obstacle blocks.
REQ-015 state  out  2  IDLE=0, PLAYING=1, CRASHED=2.
REQ-016 score  out  20  five-digit BCD score, digit 0 in [3:0].
REQ-017 hi_score  out  20  five-digit BCD best score.

Function
REQ-018 All outputs SHALL be registered; every output updates at the clk edge following the inputs that cause it.
REQ-019 press SHALL be jump_btn AND NOT btn_q, where btn_q is jump_btn delayed one cycle; a held button yields exactly one press.
REQ-020 timer SHALL increment every cycle in all states and wrap 59 -> 0.
REQ-021 IDLE: press -> PLAYING, jump = 1 for that one cycle; otherwise stay in IDLE. collision is ignored in IDLE.
REQ-022 PLAYING: collision -> CRASHED, crash = 1; collision has priority over a same-cycle press (jump = 0).
REQ-023 PLAYING without collision: press -> jump = 1 for one cycle; otherwise jump = 0.
REQ-024 Distance: each non-collision PLAYING cycle, sum = acc + speed; sum >= DIST_PER_POINT -> acc = sum - DIST_PER_POINT, score +1; else acc = sum. acc is 6 bits.
REQ-025 Score increment SHALL be BCD with digit carry (9 -> 0, carry to the next digit). It saturates at 99999.
REQ-026 Speed: speed_cnt counts non-collision PLAYING cycles. On reaching SPEED_STEP-1, speed_cnt goes to 0 and speed +1 unless speed == SPEED_MAX.
REQ-027 On the PLAYING -> CRASHED edge, hi_score SHALL load score if score > hi_score (BCD compare); score, speed and acc freeze.
REQ-028 CRASHED: crash_cnt is cleared on entry, increments each cycle, and saturates at RESTART_DELAY.
REQ-029 CRASHED: press with crash_cnt == RESTART_DELAY -> PLAYING, restart = 1 for one cycle, crash = 0, jump = 0.
REQ-030 On that restart edge: score = 0, speed = SPEED_INIT, acc = 0, speed_cnt = 0. hi_score and timer are kept.
REQ-031 CRASHED: a press with crash_cnt < RESTART_DELAY SHALL be discarded and not queued.
REQ-032 jump and restart SHALL never be 1 in the same cycle.
REQ-033 An undefined state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-034 rst = 0 SHALL immediately force these values: state = IDLE, timer = 0, speed = SPEED_INIT, score = 0, hi_score = 0, jump = 0, crash = 0, restart = 0, acc = 0, speed_cnt = 0, crash_cnt = 0, btn_q = 0.
REQ-035 Reset asserted mid-game SHALL abandon the game without a hi_score update.

Verification
REQ-036 Start: reset, hold jump_btn = 1 for 5 cycles -> state = 1 and a single jump pulse one cycle after the press; no second pulse.
REQ-037 Scoring: play 7 cycles with no collision at speed 6 -> score = 00001, acc = 2; force score 00009 then one point -> 00010; force 99999 -> stays 99999.
REQ-038 Speed ramp: 300 PLAYING cycles -> speed 7; 2100 cycles -> speed 13; further cycles stay at 13.
REQ-039 Crash: collision and press in the same cycle at score 00123, hi_score 00050 -> state = 2, crash = 1, jump = 0, hi_score = 00123. Then a crash at score 00010 leaves hi_score = 00123.
REQ-040 Restart gating: press 10 cycles after crash -> ignored. Press after 45 cycles -> restart pulse, state = 1, score = 0, speed = 6, hi_score kept.
REQ-041 Async reset: drop rst between clock edges mid-game -> all outputs at reset values before the next edge; timer wraps 59 -> 0 after release.
